// File: rtl/otter_trap_ctrl_pkg.sv
// Shared types for the OTTER trap sequencer: CSR op codes, sequencer states
// and the fixed trap-event priority order.
package otter_trap_ctrl_pkg;

    typedef enum logic [2:0] {
        CSR_OP_NONE   = 3'd0,
        CSR_OP_INTRPT = 3'd1,
        CSR_OP_TRAP   = 3'd2,
        CSR_OP_EBREAK = 3'd3,
        CSR_OP_ECALL  = 3'd4,
        CSR_OP_MRET   = 3'd5,
        CSR_OP_WFI    = 3'd6
    } csr_op_e;

    typedef enum logic [1:0] {
        TC_IDLE     = 2'd0,
        TC_REDIRECT = 2'd1,
        TC_SLEEP    = 2'd2
    } tc_state_e;

    // Event bit positions, lowest index wins.
    localparam int EV_INTR  = 0;
    localparam int EV_ILL   = 1;
    localparam int EV_EBRK  = 2;
    localparam int EV_ECALL = 3;
    localparam int EV_MRET  = 4;
    localparam int EV_WFI   = 5;
    localparam int EV_N     = 6;

    function automatic csr_op_e ev_to_op(input int idx);
        case (idx)
            EV_INTR:  return CSR_OP_INTRPT;
            EV_ILL:   return CSR_OP_TRAP;
            EV_EBRK:  return CSR_OP_EBREAK;
            EV_ECALL: return CSR_OP_ECALL;
            EV_MRET:  return CSR_OP_MRET;
            EV_WFI:   return CSR_OP_WFI;
            default:  return CSR_OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/otter_trap_prio.sv
// Combinational priority encoder: picks the single winning trap event and
// the CSR op code that goes with it.
module otter_trap_prio
    import otter_trap_ctrl_pkg::*;
(
    input  logic [EV_N-1:0] i_req,
    output logic [EV_N-1:0] o_ev,
    output csr_op_e         o_op
);

    logic [EV_N-1:0] w_blocked;

    assign w_blocked[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < EV_N; gi++) begin : g_prio
            assign o_ev[gi] = i_req[gi] & ~w_blocked[gi];
            if (gi < EV_N - 1) begin : g_chain
                assign w_blocked[gi+1] = w_blocked[gi] | i_req[gi];
            end
        end
    endgenerate

    always_comb begin
        o_op = CSR_OP_NONE;
        for (int k = 0; k < EV_N; k++) begin
            if (o_ev[k]) o_op = ev_to_op(k);
        end
    end

endmodule

// File: rtl/otter_trap_ctrl.sv
// Trap/privilege sequencer: arbitrates trap sources of the retiring
// instruction, drives the CSR op, issues a one-cycle redirect and handles WFI.
module otter_trap_ctrl
    import otter_trap_ctrl_pkg::*;
#(
    parameter int MEI_CAUSE   = 11,
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_vld,
    input  logic        is_ecall,
    input  logic        is_ebreak,
    input  logic        is_mret,
    input  logic        is_wfi,
    input  logic        is_illegal,
    input  logic        intrpt_vld,
    input  logic        intrpt_pend,
    input  logic [31:0] pc,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic [2:0]  csr_op,
    output logic        flush,
    output logic        stall,
    output logic        pc_redirect,
    output logic [31:0] trap_pc,
    output logic [31:0] csr_pc
);

    tc_state_e   r_state;
    logic [31:0] r_trap_pc;
    logic [31:0] r_wfi_pc;

    logic            w_take;
    logic [EV_N-1:0] w_req;
    logic [EV_N-1:0] w_ev;
    csr_op_e         w_prio_op;
    logic [31:0]     w_base;
    logic [31:0]     w_intr_tgt;
    logic            w_sleep_intr;

    // Decode inputs only matter for an instruction retiring while IDLE.
    assign w_take = instr_vld && (r_state == TC_IDLE) && !rst;
    assign w_req  = {is_wfi, is_mret, is_ecall, is_ebreak, is_illegal, intrpt_vld}
                    & {EV_N{w_take}};

    otter_trap_prio u_prio (
        .i_req (w_req),
        .o_ev  (w_ev),
        .o_op  (w_prio_op)
    );

    assign w_base       = {mtvec[31:2], 2'b00};
    assign w_intr_tgt   = (VECTORED_EN && (mtvec[1:0] == 2'b01))
                          ? w_base + 32'(4 * MEI_CAUSE) : w_base;
    assign w_sleep_intr = (r_state == TC_SLEEP) && intrpt_pend && intrpt_vld;

    always_comb begin
        csr_op = CSR_OP_NONE;
        flush  = 1'b0;
        stall  = 1'b0;
        case (r_state)
            TC_IDLE: begin
                csr_op = w_prio_op;
                flush  = |w_ev[EV_MRET:EV_INTR];
                stall  = |w_ev;
            end
            TC_SLEEP: begin
                stall = 1'b1;
                if (w_sleep_intr) csr_op = CSR_OP_INTRPT;
            end
            default: ;
        endcase
    end

    assign pc_redirect = (r_state == TC_REDIRECT);
    assign trap_pc     = r_trap_pc;
    // An interrupt taken from sleep must record the instruction after WFI.
    assign csr_pc      = (r_state == TC_SLEEP) ? r_wfi_pc : pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= TC_IDLE;
            r_trap_pc <= 32'd0;
            r_wfi_pc  <= 32'd0;
        end else begin
            case (r_state)
                TC_IDLE: begin
                    if (w_ev[EV_INTR]) begin
                        r_trap_pc <= w_intr_tgt;
                        r_state   <= TC_REDIRECT;
                    end else if (w_ev[EV_ILL] || w_ev[EV_EBRK] || w_ev[EV_ECALL]) begin
                        r_trap_pc <= w_base;
                        r_state   <= TC_REDIRECT;
                    end else if (w_ev[EV_MRET]) begin
                        r_trap_pc <= mepc;
                        r_state   <= TC_REDIRECT;
                    end else if (w_ev[EV_WFI]) begin
                        r_wfi_pc  <= pc + 32'd4;
                        r_state   <= TC_SLEEP;
                    end
                end
                TC_REDIRECT: r_state <= TC_IDLE;
                TC_SLEEP: begin
                    if (intrpt_pend) begin
                        r_trap_pc <= intrpt_vld ? w_intr_tgt : r_wfi_pc;
                        r_state   <= TC_REDIRECT;
                    end
                end
                default: r_state <= TC_IDLE;
            endcase
        end
    end

    a_no_double_redirect: assert property (
        @(posedge clk) disable iff (rst) pc_redirect |=> !pc_redirect);

    a_csr_op_legal: assert property (
        @(posedge clk) disable iff (rst)
        (csr_op != CSR_OP_NONE) |->
            ((r_state == TC_IDLE) && instr_vld) || ((r_state == TC_SLEEP) && intrpt_pend));

endmodule

// File: tb/tb_otter_trap_ctrl.sv
// Directed and randomized checks of otter_trap_ctrl against a behavioural
// model, for both vectored and non-vectored builds.
module tb_otter_trap_ctrl;
    import otter_trap_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_vld = 0, is_ecall = 0, is_ebreak = 0, is_mret = 0;
    logic        is_wfi = 0, is_illegal = 0, intrpt_vld = 0, intrpt_pend = 0;
    logic [31:0] pc = 0, mtvec = 0, mepc = 0;

    logic [2:0]  csr_op [2];
    logic        flush [2], stall [2], pc_redirect [2];
    logic [31:0] trap_pc [2], csr_pc [2];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    otter_trap_ctrl #(.MEI_CAUSE(11), .VECTORED_EN(1'b1)) dut_v (
        .clk(clk), .rst(rst), .instr_vld(instr_vld), .is_ecall(is_ecall),
        .is_ebreak(is_ebreak), .is_mret(is_mret), .is_wfi(is_wfi),
        .is_illegal(is_illegal), .intrpt_vld(intrpt_vld), .intrpt_pend(intrpt_pend),
        .pc(pc), .mtvec(mtvec), .mepc(mepc), .csr_op(csr_op[0]), .flush(flush[0]),
        .stall(stall[0]), .pc_redirect(pc_redirect[0]), .trap_pc(trap_pc[0]),
        .csr_pc(csr_pc[0]));

    otter_trap_ctrl #(.MEI_CAUSE(11), .VECTORED_EN(1'b0)) dut_nv (
        .clk(clk), .rst(rst), .instr_vld(instr_vld), .is_ecall(is_ecall),
        .is_ebreak(is_ebreak), .is_mret(is_mret), .is_wfi(is_wfi),
        .is_illegal(is_illegal), .intrpt_vld(intrpt_vld), .intrpt_pend(intrpt_pend),
        .pc(pc), .mtvec(mtvec), .mepc(mepc), .csr_op(csr_op[1]), .flush(flush[1]),
        .stall(stall[1]), .pc_redirect(pc_redirect[1]), .trap_pc(trap_pc[1]),
        .csr_pc(csr_pc[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        instr_vld = 0; is_ecall = 0; is_ebreak = 0; is_mret = 0;
        is_wfi = 0; is_illegal = 0; intrpt_vld = 0; intrpt_pend = 0;
    endtask

    function automatic logic [31:0] intr_target(input bit vec, input logic [31:0] tv);
        logic [31:0] base;
        base = tv & 32'hFFFF_FFFC;
        return (vec && tv[1:0] == 2'b01) ? base + 32'd44 : base;
    endfunction

    // Behavioural model state: 0 = normal, 1 = redirect due, 2 = asleep.
    int          m_mode;
    logic [31:0] m_tgt [2];
    logic [31:0] m_wfi;

    initial begin
        // Reset state
        #2;
        chk("rst_op", 32'(csr_op[0]), 32'(CSR_OP_NONE));
        chk("rst_flush", 32'(flush[0]), 0);
        chk("rst_stall", 32'(stall[0]), 0);
        chk("rst_redirect", 32'(pc_redirect[0]), 0);
        chk("rst_trap_pc", trap_pc[0], 0);
        tick();
        rst = 0;

        // ECALL (decode lines left high in REDIRECT must be ignored)
        tick();
        instr_vld = 1; is_ecall = 1; pc = 32'h100; mtvec = 32'h200;
        #1;
        chk("ecall_op", 32'(csr_op[0]), 32'(CSR_OP_ECALL));
        chk("ecall_flush", 32'(flush[0]), 1);
        chk("ecall_stall", 32'(stall[0]), 1);
        chk("ecall_csr_pc", csr_pc[0], 32'h100);
        chk("ecall_no_redir", 32'(pc_redirect[0]), 0);
        tick();
        #1;
        chk("ecall_redir", 32'(pc_redirect[0]), 1);
        chk("ecall_trap_pc", trap_pc[0], 32'h200);
        chk("ecall_redir_op", 32'(csr_op[0]), 32'(CSR_OP_NONE));
        chk("ecall_redir_stall", 32'(stall[0]), 0);
        tick();
        clr();
        #1;
        chk("ecall_single", 32'(pc_redirect[0]), 0);
        chk("ecall_hold_pc", trap_pc[0], 32'h200);

        // Interrupt beats ECALL, vectored vs non-vectored
        tick();
        instr_vld = 1; intrpt_vld = 1; is_ecall = 1; pc = 32'h40; mtvec = 32'h301;
        #1;
        chk("intr_op", 32'(csr_op[0]), 32'(CSR_OP_INTRPT));
        chk("intr_flush", 32'(flush[0]), 1);
        tick();
        clr();
        #1;
        chk("intr_redir", 32'(pc_redirect[0]), 1);
        chk("intr_vec_pc", trap_pc[0], 32'h32C);
        chk("intr_novec_pc", trap_pc[1], 32'h300);

        // MRET
        tick();
        instr_vld = 1; is_mret = 1; mepc = 32'h1234;
        #1;
        chk("mret_op", 32'(csr_op[0]), 32'(CSR_OP_MRET));
        tick();
        clr();
        #1;
        chk("mret_redir", 32'(pc_redirect[0]), 1);
        chk("mret_pc", trap_pc[0], 32'h1234);
        tick();
        #1;
        chk("mret_single", 32'(pc_redirect[0]), 0);

        // WFI, sleep, resume without interrupt
        instr_vld = 1; is_wfi = 1; pc = 32'h80;
        #1;
        chk("wfi_op", 32'(csr_op[0]), 32'(CSR_OP_WFI));
        chk("wfi_flush", 32'(flush[0]), 0);
        tick();
        clr();
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("sleep_stall", 32'(stall[0]), 1);
            chk("sleep_op", 32'(csr_op[0]), 32'(CSR_OP_NONE));
            chk("sleep_csr_pc", csr_pc[0], 32'h84);
            tick();
            #1;
        end
        intrpt_pend = 1;
        #1;
        chk("resume_op", 32'(csr_op[0]), 32'(CSR_OP_NONE));
        tick();
        clr();
        #1;
        chk("resume_redir", 32'(pc_redirect[0]), 1);
        chk("resume_pc", trap_pc[0], 32'h84);

        // WFI, wake by interrupt
        tick();
        instr_vld = 1; is_wfi = 1; pc = 32'h80; mtvec = 32'h200;
        tick();
        clr();
        pc = 32'h999;
        intrpt_pend = 1; intrpt_vld = 1;
        #1;
        chk("wake_op", 32'(csr_op[0]), 32'(CSR_OP_INTRPT));
        chk("wake_csr_pc", csr_pc[0], 32'h84);
        tick();
        clr();
        #1;
        chk("wake_redir", 32'(pc_redirect[0]), 1);
        chk("wake_pc", trap_pc[0], 32'h200);

        // WFI at top of address space
        tick();
        instr_vld = 1; is_wfi = 1; pc = 32'hFFFF_FFFC;
        tick();
        clr();
        #1;
        chk("wrap_csr_pc", csr_pc[0], 32'h0);
        intrpt_pend = 1;
        tick();
        clr();
        #1;
        chk("wrap_pc", trap_pc[0], 32'h0);

        // Async reset while asleep
        tick();
        instr_vld = 1; is_wfi = 1; pc = 32'h10;
        tick();
        clr();
        #1;
        chk("rsleep_pre", 32'(stall[0]), 1);
        rst = 1;
        #1;
        chk("rsleep_stall", 32'(stall[0]), 0);
        chk("rsleep_trap_pc", trap_pc[0], 0);
        tick();
        rst = 0;
        intrpt_pend = 1;
        #1;
        chk("rsleep_idle", 32'(stall[0]), 0);
        tick();
        #1;
        chk("rsleep_no_redir", 32'(pc_redirect[0]), 0);
        clr();

        // Async reset during redirect
        tick();
        instr_vld = 1; is_ecall = 1; pc = 32'h20; mtvec = 32'h400;
        tick();
        clr();
        #1;
        chk("rredir_pre", 32'(pc_redirect[0]), 1);
        rst = 1;
        #1;
        chk("rredir_redir", 32'(pc_redirect[0]), 0);
        chk("rredir_trap_pc", trap_pc[0], 0);
        tick();
        rst = 0;
        tick();
        #1;
        chk("rredir_no_redir", 32'(pc_redirect[0]), 0);

        // Randomized phase
        m_mode = 0; m_tgt[0] = 0; m_tgt[1] = 0; m_wfi = 0;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r, e_op, nxt_tgt [2];
            logic        e_flush, e_stall, chk_stall;
            int          nxt_mode;
            tick();
            r = $urandom;
            instr_vld = r[0] | r[1];
            intrpt_vld = (r[4:2] == 3'd0);
            is_illegal = (r[7:5] == 3'd0);
            is_ebreak = (r[10:8] == 3'd0);
            is_ecall = (r[13:11] == 3'd0);
            is_mret = (r[16:14] == 3'd0);
            is_wfi = (r[19:17] < 3'd3);
            intrpt_pend = (r[22:20] < 3'd2) | intrpt_vld;
            pc = (r[25:23] == 3'd0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            mtvec = ($urandom & 32'hFFFF_FFFC) | {31'd0, r[26]};
            mepc = $urandom;
            #1;
            e_op = 32'(CSR_OP_NONE); e_flush = 0; e_stall = 0; chk_stall = 1;
            nxt_mode = 0; nxt_tgt = m_tgt;
            if (m_mode == 1) begin
                chk("rnd_redir", 32'(pc_redirect[0]), 1);
            end else begin
                chk("rnd_redir", 32'(pc_redirect[0]), 0);
                if (m_mode == 2) begin
                    e_stall = 1;
                    nxt_mode = 2;
                    chk("rnd_sleep_csr_pc", csr_pc[0], m_wfi);
                    if (intrpt_pend) begin
                        chk_stall = 0;
                        nxt_mode = 1;
                        if (intrpt_vld) begin
                            e_op = 32'(CSR_OP_INTRPT);
                            for (int k = 0; k < 2; k++) nxt_tgt[k] = intr_target(k == 0, mtvec);
                        end else begin
                            nxt_tgt[0] = m_wfi; nxt_tgt[1] = m_wfi;
                        end
                    end
                end else if (instr_vld) begin
                    nxt_mode = 1; e_flush = 1; e_stall = 1;
                    if (intrpt_vld) begin
                        e_op = 32'(CSR_OP_INTRPT);
                        for (int k = 0; k < 2; k++) nxt_tgt[k] = intr_target(k == 0, mtvec);
                    end else if (is_illegal || is_ebreak || is_ecall) begin
                        e_op = is_illegal ? 32'(CSR_OP_TRAP) :
                               is_ebreak ? 32'(CSR_OP_EBREAK) : 32'(CSR_OP_ECALL);
                        nxt_tgt[0] = mtvec & 32'hFFFF_FFFC; nxt_tgt[1] = nxt_tgt[0];
                    end else if (is_mret) begin
                        e_op = 32'(CSR_OP_MRET);
                        nxt_tgt[0] = mepc; nxt_tgt[1] = mepc;
                    end else if (is_wfi) begin
                        e_op = 32'(CSR_OP_WFI);
                        e_flush = 0; chk_stall = 0; nxt_mode = 2;
                        m_wfi = pc + 32'd4;
                    end else begin
                        nxt_mode = 0; e_flush = 0; e_stall = 0;
                    end
                end
            end
            if (m_mode != 2) chk("rnd_csr_pc", csr_pc[0], pc);
            for (int k = 0; k < 2; k++) begin
                chk("rnd_op", 32'(csr_op[k]), e_op);
                chk("rnd_flush", 32'(flush[k]), 32'(e_flush));
                if (chk_stall) chk("rnd_stall", 32'(stall[k]), 32'(e_stall));
                chk("rnd_trap_pc", trap_pc[k], m_tgt[k]);
            end
            m_mode = nxt_mode;
            m_tgt = nxt_tgt;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
